// File: rtl/axi4_lite_slave_ranged.sv
// axi4_lite_slave_ranged: AXI4-Lite slave bridging to a write-pulse / read-request peripheral bus
// with address-window decode, SLVERR on miss and a read-timeout guard.
module axi4_lite_slave_ranged #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter longint unsigned REGION_SIZE = 4096,
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] byte_en,
  output logic [ADDR_WIDTH-1:0]   write_addr,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic                    mem_read,
  output logic [ADDR_WIDTH-1:0]   read_addr,
  input  logic [DATA_WIDTH-1:0]   read_data,
  input  logic                    data_valid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CW = $clog2(RD_TIMEOUT);
  localparam logic [ADDR_WIDTH:0] LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] SIZE = (ADDR_WIDTH + 1)'(REGION_SIZE);
  typedef enum logic [1:0] {W_IDLE, W_AHELD, W_DHELD, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  // Offset is taken one bit wider, so addresses below the base wrap far above SIZE.
  function automatic logic hit(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} - LO) < SIZE;
  endfunction
  w_state_t ws, ws_n;
  r_state_t rs, rs_n;
  logic [CW-1:0] cnt;
  logic aw_hs, w_hs, ar_hs, w_enter;
  logic [ADDR_WIDTH-1:0] wa_d;
  logic [STRB_W-1:0] wb_d;
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign wa_d = aw_hs ? s_axi_awaddr : write_addr;
  assign wb_d = w_hs ? s_axi_wstrb : byte_en;
  assign w_enter = ws_n == W_RESP && ws != W_RESP;
  assign s_axi_bvalid = ws == W_RESP;
  assign s_axi_rvalid = rs == R_RESP;
  always_comb begin
    ws_n = ws;
    case (ws)
      W_IDLE:  ws_n = aw_hs && w_hs ? W_RESP : aw_hs ? W_AHELD : w_hs ? W_DHELD : W_IDLE;
      W_AHELD: ws_n = w_hs ? W_RESP : W_AHELD;
      W_DHELD: ws_n = aw_hs ? W_RESP : W_DHELD;
      default: ws_n = s_axi_bready ? W_IDLE : W_RESP;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ws <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready <= 1'b0;
      s_axi_bresp <= 2'b00;
      mem_write <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      byte_en <= '0;
    end else begin
      ws <= ws_n;
      s_axi_awready <= ws_n == W_IDLE || ws_n == W_DHELD;
      s_axi_wready <= ws_n == W_IDLE || ws_n == W_AHELD;
      mem_write <= w_enter && hit(wa_d) && |wb_d;
      if (w_enter) s_axi_bresp <= hit(wa_d) ? 2'b00 : 2'b10;
      if (aw_hs) write_addr <= s_axi_awaddr;
      if (w_hs) write_data <= s_axi_wdata;
      if (w_hs) byte_en <= s_axi_wstrb;
    end
  end
  always_comb begin
    rs_n = rs;
    case (rs)
      R_IDLE:  rs_n = !ar_hs ? R_IDLE : hit(s_axi_araddr) ? R_WAIT : R_RESP;
      R_WAIT:  rs_n = data_valid || cnt == CW'(RD_TIMEOUT - 1) ? R_RESP : R_WAIT;
      default: rs_n = s_axi_rready ? R_IDLE : R_RESP;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_rresp <= 2'b00;
      mem_read <= 1'b0;
      read_addr <= '0;
      cnt <= '0;
    end else begin
      rs <= rs_n;
      s_axi_arready <= rs_n == R_IDLE;
      mem_read <= rs == R_IDLE && rs_n == R_WAIT;
      cnt <= rs == R_WAIT ? cnt + 1'b1 : '0;
      if (ar_hs) read_addr <= s_axi_araddr;
      // Data only counts if it arrived in R_WAIT; misses and timeouts return zero.
      if (rs != R_RESP && rs_n == R_RESP) begin
        s_axi_rdata <= rs == R_WAIT && data_valid ? read_data : '0;
        s_axi_rresp <= rs == R_WAIT && data_valid ? 2'b00 : 2'b10;
      end
    end
  end
endmodule
